// File: rtl/movsum_inv.sv
// rtl/movsum_inv.sv - streaming inverse of the 4-tap moving-sum filter
module movsum_inv #(
  parameter int WL = 64,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic [WL-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [WL-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [CW-1:0] count
);

  logic          en;
  logic          accept;
  logic          s1_v;
  logic [WL-1:0] s1_d;
  logic [WL-1:0] yprev;
  logic [WL-1:0] x1;
  logic [WL-1:0] x2;
  logic [WL-1:0] x3;
  logic [WL-1:0] x4;
  logic [WL-1:0] x_new;

  // The whole pipeline advances together whenever the output register is free.
  assign en        = !dout_valid || dout_ready;
  assign din_ready = en && !clr;
  assign accept    = din_valid && din_ready;

  // x[n] = (y[n] - y[n-1]) + x[n-4]; the difference is already in s1_d.
  assign x_new = s1_d + x4;

  // Difference stage, output stage and recovered-sample history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      yprev      <= '0;
      s1_d       <= '0;
      s1_v       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      x1         <= '0;
      x2         <= '0;
      x3         <= '0;
      x4         <= '0;
    end else if (clr) begin
      // Resync to a freshly reset filter: all-zero history, nothing in flight.
      yprev      <= '0;
      s1_d       <= '0;
      s1_v       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      x1         <= '0;
      x2         <= '0;
      x3         <= '0;
      x4         <= '0;
    end else if (en) begin
      s1_v <= accept;
      if (accept) begin
        s1_d  <= din - yprev;
        yprev <= din;
      end
      dout_valid <= s1_v;
      if (s1_v) begin
        dout <= x_new;
        x1   <= x_new;
        x2   <= x1;
        x3   <= x2;
        x4   <= x3;
      end
    end
  end

  // Delivered-sample counter; clr wins even over a same-cycle handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (dout_valid && dout_ready) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: tb/tb_movsum_inv.sv
// tb/tb_movsum_inv.sv - directed self-checking bench for movsum_inv
module tb_movsum_inv;

  localparam int WL = 64;
  localparam int CW = 32;

  typedef logic [WL-1:0] q_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr = 1'b0;
  logic [WL-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [WL-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic [CW-1:0] count;

  int total = 0;
  int bad = 0;
  q_t got;
  int rdy_viol;
  int hold_viol;
  int stall_seen;
  int first_acc;
  int first_val;

  movsum_inv #(.WL(WL), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Output collector: every handshake seen at a rising edge.
  always @(posedge clk) begin
    if (reset && dout_valid && dout_ready) got.push_back(dout);
  end

  // Reference 4-tap moving sum starting from all-zero history.
  function automatic q_t mk_ys(input q_t xs);
    q_t ys;
    logic [WL-1:0] h1, h2, h3;
    h1 = '0; h2 = '0; h3 = '0;
    foreach (xs[i]) begin
      ys.push_back(xs[i] + h1 + h2 + h3);
      h3 = h2; h2 = h1; h1 = xs[i];
    end
    return ys;
  endfunction

  task automatic do_clr();
    din_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    got.delete();
  endtask

  // Cycle-level driver; dout_ready drops for 3 cycles starting at stall_s.
  task automatic run(input q_t ys, input bit bubble, input int stall_s);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    bit pstall = 1'b0;
    logic [WL-1:0] pdout = '0;
    first_acc = -1; first_val = -1;
    rdy_viol = 0; hold_viol = 0; stall_seen = 0;
    while ((idx < ys.size() || got.size() < ys.size()) && cyc < 1000) begin
      din_valid  = (idx < ys.size()) && (!bubble || $urandom_range(0, 2) != 0);
      din        = (idx < ys.size()) ? ys[idx] : '0;
      dout_ready = !(cyc >= stall_s && cyc < stall_s + 3);
      @(negedge clk);
      rdy = din_ready;
      if (rdy !== !(dout_valid && !dout_ready)) rdy_viol++;
      if (pstall && (dout !== pdout || dout_valid !== 1'b1)) hold_viol++;
      pstall = dout_valid && !dout_ready;
      if (pstall) stall_seen++;
      pdout = dout;
      if (dout_valid && first_val < 0) first_val = cyc;
      @(posedge clk);
      if (din_valid && rdy) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
      end
      #1 cyc++;
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    total++;
    if (cyc >= 1000) begin
      bad++;
      $display("FAIL run_timeout: got %0d outputs, need %0d", got.size(), ys.size());
    end
  endtask

  task automatic test_reset();
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", dout); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
  endtask

  task automatic test_impulse(input string tag);
    q_t ys;
    logic [WL-1:0] exp_v[8] = '{5, 0, 0, 0, 0, 0, 0, 0};
    ys = '{64'd5, 64'd5, 64'd5, 64'd5, 64'd0, 64'd0, 64'd0, 64'd0};
    got.delete();
    run(ys, 1'b0, -10);
    total++;
    if (first_val - first_acc !== 2) begin
      bad++; $display("FAIL %s_latency: got %0d cycles want 2", tag, first_val - first_acc);
    end
    total++;
    if (got.size() !== 8) begin
      bad++; $display("FAIL %s_size: got %0d want 8", tag, got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_v[i]) begin
        bad++; $display("FAIL %s_dout[%0d]: got %0d want %0d", tag, i, got[i], exp_v[i]);
      end
    end
    total++;
    if (count !== 32'd8) begin
      bad++; $display("FAIL %s_count: got %0d want 8", tag, count);
    end
  endtask

  task automatic test_ramp();
    q_t xs;
    int errs = 0;
    do_clr();
    for (int i = 1; i <= 100; i++) xs.push_back(WL'(i));
    run(mk_ys(xs), 1'b0, -10);
    total++;
    if (got.size() !== 100) begin
      bad++; $display("FAIL ramp_size: got %0d want 100", got.size());
    end
    for (int i = 0; i < got.size() && i < 100; i++) begin
      total++;
      if (got[i] !== WL'(i + 1)) begin
        bad++; errs++;
        if (errs < 5) $display("FAIL ramp_dout[%0d]: got %0d want %0d", i, got[i], i + 1);
      end
    end
    total++;
    if (got.size() < 50 || got[49] !== 64'd50) begin
      bad++; $display("FAIL ramp_50th: got %0d want 50", got.size() < 50 ? 0 : got[49]);
    end
  endtask

  task automatic test_wrap();
    q_t xs;
    q_t ys;
    for (int i = 0; i < 8; i++) xs.push_back('1);
    ys = mk_ys(xs);
    do_clr();
    run(ys, 1'b0, -10);
    total++;
    if (got.size() !== 8) begin
      bad++; $display("FAIL wrap_size: got %0d want 8", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
        bad++; $display("FAIL wrap_dout[%0d]: got %h want ffffffffffffffff", i, got[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    q_t xs;
    q_t ys;
    q_t ref_out;
    for (int i = 0; i < 20; i++) xs.push_back(WL'(i * 37 + 5) ^ 64'hA5A5_0000_0000_0000);
    ys = mk_ys(xs);
    do_clr();
    run(ys, 1'b0, -10);
    ref_out = got;
    do_clr();
    run(ys, 1'b1, 6);
    total++; if (rdy_viol !== 0) begin bad++; $display("FAIL bp_din_ready: %0d bad cycles want 0", rdy_viol); end
    total++; if (hold_viol !== 0) begin bad++; $display("FAIL bp_hold: %0d changed cycles want 0", hold_viol); end
    total++; if (stall_seen < 1) begin bad++; $display("FAIL bp_stall_seen: got %0d want >=1", stall_seen); end
    total++; if (got.size() !== 20) begin bad++; $display("FAIL bp_size: got %0d want 20", got.size()); end
    for (int i = 0; i < got.size() && i < 20; i++) begin
      total++;
      if (got[i] !== xs[i] || got[i] !== ref_out[i]) begin
        bad++; $display("FAIL bp_dout[%0d]: got %h want %h", i, got[i], xs[i]);
      end
    end
  endtask

  task automatic test_clr();
    q_t xs;
    q_t ys;
    logic [WL-1:0] exp_v[4] = '{7, 0, 0, 0};
    do_clr();
    for (int i = 0; i < 10; i++) xs.push_back(WL'(i * 11 + 3));
    run(mk_ys(xs), 1'b0, -10);
    total++; if (count !== 32'd10) begin bad++; $display("FAIL clr_precount: got %0d want 10", count); end
    din = 64'd99;
    din_valid = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL clr_din_ready: got %b want 0", din_ready); end
    @(posedge clk);
    #1 clr = 1'b0;
    din_valid = 1'b0;
    total++; if (count !== '0) begin bad++; $display("FAIL clr_count: got %0d want 0", count); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL clr_dout_valid: got %b want 0", dout_valid); end
    got.delete();
    ys = '{64'd7, 64'd7, 64'd7, 64'd7};
    run(ys, 1'b0, -10);
    total++; if (got.size() !== 4) begin bad++; $display("FAIL clr_size: got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] !== exp_v[i]) begin
        bad++; $display("FAIL clr_dout[%0d]: got %0d want %0d", i, got[i], exp_v[i]);
      end
    end
    total++; if (count !== 32'd4) begin bad++; $display("FAIL clr_count_end: got %0d want 4", count); end
  endtask

  task automatic test_async_reset();
    dout_ready = 1'b0;
    din = 64'd3;
    din_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    din_valid = 1'b0;
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL ar_filled: got dout_valid %b want 1", dout_valid); end
    total++; if (count !== 32'd4) begin bad++; $display("FAIL ar_precount: got %0d want 4", count); end
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL ar_dout_valid: got %b want 0", dout_valid); end
    total++; if (count !== '0) begin bad++; $display("FAIL ar_count: got %0d want 0", count); end
    total++; if (dout !== '0) begin bad++; $display("FAIL ar_dout: got %h want 0", dout); end
    @(posedge clk);
    #1 reset = 1'b1;
    dout_ready = 1'b1;
    test_impulse("ar_impulse");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    test_reset();
    test_impulse("impulse");
    test_ramp();
    test_wrap();
    test_backpressure();
    test_clr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
